// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file and its clear controller.
package register_file_mp_pkg;

  localparam int XLEN    = 32;
  localparam int NUM_GPR = 32;

  typedef logic [$clog2(NUM_GPR)-1:0] t_register_index;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/register_file_mp_clear_ctrl.sv
// Clear sequencer: walks every register index once, writing zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | normal operation, waiting for a clear request
// ST_CLEAR | zeroing register clr_idx this cycle; busy, writes blocked
module register_file_clear_ctrl
  import register_file_mp_pkg::*;
#(
  parameter int NUM_REGS = NUM_GPR,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [IDX_W-1:0] o_clr_idx
);

  clr_state_e       state, state_nxt;
  logic [IDX_W-1:0] clr_idx, clr_idx_nxt;

  // State and index registers; reset lands directly in the clear sequence.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Next-state, index advance and busy/clear-write outputs.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_clear) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = '0;
        end
      end
      ST_CLEAR: begin
        o_busy      = 1'b1;
        o_clr_we    = 1'b1;
        clr_idx_nxt = clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(NUM_REGS - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_clr_idx = clr_idx;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ combinational read ports, two write
// ports (port 1 wins on collision), optional write-to-read forwarding,
// optional hard-wired zero register and a sequenced clear.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int NUM_REGS   = NUM_GPR,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_READ-1:0][IDX_W-1:0]      i_raddr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0] o_rdata,
  input  logic                                i_we0,
  input  logic [IDX_W-1:0]                    i_waddr0,
  input  logic [DATA_WIDTH-1:0]               i_wdata0,
  input  logic                                i_we1,
  input  logic [IDX_W-1:0]                    i_waddr1,
  input  logic [DATA_WIDTH-1:0]               i_wdata1,
  input  logic                                i_clear,
  output logic                                o_busy
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  clr_we;
  logic [IDX_W-1:0]      clr_idx;
  logic                  wr_open;
  logic                  we0_ok;
  logic                  we1_ok;

  register_file_clear_ctrl #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_ctrl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (i_clear),
    .o_busy    (o_busy),
    .o_clr_we  (clr_we),
    .o_clr_idx (clr_idx)
  );

  // A clear request in the same cycle as a write takes priority and drops it.
  assign wr_open = !o_busy && !i_clear;
  assign we0_ok  = i_we0 && wr_open && (ZERO_REG == 0 || i_waddr0 != '0);
  assign we1_ok  = i_we1 && wr_open && (ZERO_REG == 0 || i_waddr1 != '0);

  // Array update; the later port-1 assignment wins an index collision.
  // No reset here: contents are zeroed only by the clear sequence.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else begin
      if (we0_ok) mem[i_waddr0] <= i_wdata0;
      if (we1_ok) mem[i_waddr1] <= i_wdata1;
    end
  end

  // Read muxing: busy and the zero register override everything, then forwarding.
  always_comb begin
    o_rdata = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      if (o_busy) begin
        o_rdata[r] = '0;
      end else if (ZERO_REG != 0 && i_raddr[r] == '0) begin
        o_rdata[r] = '0;
      end else if (BYPASS != 0 && we1_ok && i_waddr1 == i_raddr[r]) begin
        o_rdata[r] = i_wdata1;
      end else if (BYPASS != 0 && we0_ok && i_waddr0 == i_raddr[r]) begin
        o_rdata[r] = i_wdata0;
      end else begin
        o_rdata[r] = mem[i_raddr[r]];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: instance a uses defaults (forwarding, zero register),
// instance b is built without forwarding and without the zero register.
module tb_register_file_mp;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [1:0][4:0]  i_raddr;
  logic [1:0][31:0] rdata_a, rdata_b;
  logic             i_we0, i_we1, i_clear;
  logic [4:0]       i_waddr0, i_waddr1;
  logic [31:0]      i_wdata0, i_wdata1;
  logic             busy_a, busy_b;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 i_clk = ~i_clk;

  register_file_mp dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_raddr(i_raddr), .o_rdata(rdata_a),
    .i_we0(i_we0), .i_waddr0(i_waddr0), .i_wdata0(i_wdata0),
    .i_we1(i_we1), .i_waddr1(i_waddr1), .i_wdata1(i_wdata1),
    .i_clear(i_clear), .o_busy(busy_a)
  );

  register_file_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_raddr(i_raddr), .o_rdata(rdata_b),
    .i_we0(i_we0), .i_waddr0(i_waddr0), .i_wdata0(i_wdata0),
    .i_we1(i_we1), .i_waddr1(i_waddr1), .i_wdata1(i_wdata1),
    .i_clear(i_clear), .o_busy(busy_b)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic [31:0] eb0;
    logic [31:0] eb1;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts negedge samples with busy high on instance a, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (cnt < 200) begin
      @(negedge i_clk);
      if (!busy_a) break;
      cnt++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      i_raddr[0] = 5'(i);
      i_raddr[1] = 5'(31 - i);
      #1;
      chk($sformatf("%s a x%0d", tag, i), rdata_a[0], 32'h0);
      chk($sformatf("%s b x%0d", tag, 31 - i), rdata_b[1], 32'h0);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,       5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1, 5'd7,  32'h1111,     1, 5'd7,  32'h2222,    5'd7,  5'd5,  32'h2222,     32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       5'd7,  5'd7,  32'h2222,     32'h2222,     32'h2222,     32'h2222};
    vecs[4]  = '{1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       5'd0,  5'd7,  32'h0,        32'h2222,     32'hFFFFFFFF, 32'h2222};
    vecs[6]  = '{1, 5'd9,  32'hAAAA,     1, 5'd10, 32'hBBBB,    5'd9,  5'd10, 32'hAAAA,     32'hBBBB,     32'h0,        32'h0};
    vecs[7]  = '{0, 5'd0,  32'h0,        1, 5'd9,  32'hCCCC,    5'd9,  5'd10, 32'hCCCC,     32'hBBBB,     32'hAAAA,     32'hBBBB};
    vecs[8]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       5'd9,  5'd10, 32'hCCCC,     32'hBBBB,     32'hCCCC,     32'hBBBB};
    vecs[9]  = '{1, 5'd31, 32'h12345678, 0, 5'd0,  32'h0,       5'd31, 5'd1,  32'h12345678, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       5'd31, 5'd30, 32'h12345678, 32'h0,        32'h12345678, 32'h0};

    i_rst = 1'b1; i_clear = 1'b0; i_raddr = '0;
    i_we0 = 1'b0; i_waddr0 = '0; i_wdata0 = '0;
    i_we1 = 1'b0; i_waddr1 = '0; i_wdata1 = '0;

    // Reset takes effect before any clock edge.
    #1;
    chk("reset busy a", 32'(busy_a), 32'h1);
    chk("reset busy b", 32'(busy_b), 32'h1);
    chk("reset rdata a", rdata_a[0], 32'h0);
    chk("reset rdata b", rdata_b[0], 32'h0);

    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    count_busy(n);
    chk("busy cycles after reset", 32'(n), 32'd32);
    chk("busy b idle after reset", 32'(busy_b), 32'h0);
    read_all_zero("post-reset");

    // Write/read vectors: values sampled before the committing edge.
    foreach (vecs[k]) begin
      @(posedge i_clk);
      #1;
      i_we0 = vecs[k].we0; i_waddr0 = vecs[k].wa0; i_wdata0 = vecs[k].wd0;
      i_we1 = vecs[k].we1; i_waddr1 = vecs[k].wa1; i_wdata1 = vecs[k].wd1;
      i_raddr[0] = vecs[k].ra0; i_raddr[1] = vecs[k].ra1;
      @(negedge i_clk);
      chk($sformatf("vec%0d a r0", k), rdata_a[0], vecs[k].ea0);
      chk($sformatf("vec%0d a r1", k), rdata_a[1], vecs[k].ea1);
      chk($sformatf("vec%0d b r0", k), rdata_b[0], vecs[k].eb0);
      chk($sformatf("vec%0d b r1", k), rdata_b[1], vecs[k].eb1);
    end

    // Fill x1..x31 with their index.
    for (int i = 1; i < 32; i++) begin
      @(posedge i_clk);
      #1;
      i_we0 = 1'b1; i_waddr0 = 5'(i); i_wdata0 = 32'(i);
      i_we1 = 1'b0;
    end
    @(posedge i_clk);
    #1 i_we0 = 1'b0;
    for (int i = 1; i < 32; i++) begin
      i_raddr[0] = 5'(i);
      #1;
      chk($sformatf("fill x%0d", i), rdata_a[0], 32'(i));
    end

    // Clear with a simultaneous write: the write must be dropped.
    @(posedge i_clk);
    #1;
    i_clear = 1'b1;
    i_we0 = 1'b1; i_waddr0 = 5'd3; i_wdata0 = 32'h55;
    i_raddr[0] = 5'd3; i_raddr[1] = 5'd3;
    @(negedge i_clk);
    chk("clear+write no fwd a", rdata_a[0], 32'h3);
    chk("clear+write busy pre-edge", 32'(busy_a), 32'h0);
    @(posedge i_clk);
    #1;
    i_clear = 1'b0; i_we0 = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge i_clk);
      if (!busy_a) break;
      n++;
      if (n == 3) begin
        chk("rdata while busy a", rdata_a[0], 32'h0);
        chk("rdata while busy b", rdata_b[1], 32'h0);
      end
      if (n == 5) begin
        i_clear = 1'b1;
        i_we1 = 1'b1; i_waddr1 = 5'd4; i_wdata1 = 32'h77;
        i_raddr[0] = 5'd4;
      end
      if (n == 6) begin
        chk("busy write no fwd", rdata_a[0], 32'h0);
        i_clear = 1'b0; i_we1 = 1'b0;
      end
    end
    chk("busy cycles clear", 32'(n), 32'd32);
    read_all_zero("post-clear");

    // Reset in the middle of a clear restarts the sequence.
    @(posedge i_clk);
    #1;
    i_we0 = 1'b1; i_waddr0 = 5'd12; i_wdata0 = 32'h99;
    @(posedge i_clk);
    #1;
    i_we0 = 1'b0; i_clear = 1'b1;
    @(posedge i_clk);
    #1;
    i_clear = 1'b0;
    i_raddr[0] = 5'd12; i_raddr[1] = 5'd12;
    n = 0;
    while (n < 10) begin
      @(negedge i_clk);
      if (!busy_a) break;
      n++;
    end
    chk("clear cycles before reset", 32'(n), 32'd10);
    i_rst = 1'b1;
    #1;
    chk("mid-clear reset busy", 32'(busy_a), 32'h1);
    chk("mid-clear reset rdata a", rdata_a[0], 32'h0);
    chk("mid-clear reset rdata b", rdata_b[1], 32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    count_busy(n);
    chk("busy cycles after mid reset", 32'(n), 32'd32);
    #1;
    chk("x12 after restart a", rdata_a[0], 32'h0);
    chk("x12 after restart b", rdata_b[1], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count (power of two, >=2); IDX_W = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_READ, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write data forwarded to reads, 0 = no forwarding.
REQ-005 SHALL have parameter ZERO_REG, default 1, meaning 1 = index 0 reads zero and ignores writes.
REQ-006 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_raddr  input  NUM_READ x IDX_W  read indices.
REQ-009 SHALL have port o_rdata  output  NUM_READ x DATA_WIDTH  read data.
REQ-010 SHALL have ports i_we0/i_waddr0/i_wdata0  input  1/IDX_W/DATA_WIDTH  write port 0.
REQ-011 SHALL have ports i_we1/i_waddr1/i_wdata1  input  1/IDX_W/DATA_WIDTH  write port 1.
REQ-012 SHALL have port i_clear  input  1  synchronous request to zero all registers.
REQ-013 SHALL have port o_busy  output  1  high while clear sequence runs; writes ignored.

Function
REQ-014 Reads SHALL be combinational from array contents; zero read latency.
REQ-015 Writes SHALL commit on the rising edge when we is high, o_busy low, and (ZERO_REG=0 or addr!=0).
REQ-016 When both write ports target the same index in one cycle, port 1 SHALL win; port 0 data discarded.
REQ-017 With BYPASS=1, a read whose index matches a qualifying write this cycle SHALL return that write data (port 1 priority), else array value.
REQ-018 With BYPASS=0, reads SHALL return pre-edge array value.
REQ-019 With ZERO_REG=1, reads of index 0 SHALL return 0 regardless of bypass.
REQ-020 Clear FSM states: IDLE, CLEAR; counter clr_idx (IDX_W bits).
REQ-021 IDLE -> CLEAR when i_clear high on an edge; clr_idx loads 0.
REQ-022 In CLEAR, each edge SHALL write 0 to register clr_idx and increment; after index NUM_REGS-1 is written, -> IDLE (NUM_REGS cycles total).
REQ-023 o_busy SHALL be high exactly while state=CLEAR.
REQ-024 While o_busy, all o_rdata SHALL read 0 and no bypass SHALL apply.
REQ-025 i_clear during CLEAR SHALL be ignored (sequence not restarted).
REQ-026 Writes presented while o_busy SHALL be dropped, not queued.
REQ-027 A write and i_clear asserted together in IDLE SHALL have the write dropped (clear wins).

Reset
REQ-028 Asserting i_rst SHALL immediately force state=CLEAR, clr_idx=0, o_busy=1, o_rdata=0, without waiting for a clock edge.
REQ-029 On deassertion, clear SHALL run NUM_REGS cycles, then o_busy=0 and all registers read 0.
REQ-030 Reset mid-clear SHALL restart the sequence from index 0.
REQ-031 The register array itself SHALL not be asynchronously reset (zeroed only by the clear sequence).

Structure
REQ-032 Default constants XLEN=32, NUM_GPR=32 and t_register_index SHALL reside in the shared definitions package; parameter defaults reference them.
REQ-033 The clear FSM and counter SHALL be one sub-module, register_file_clear_ctrl (ports: i_clk, i_rst, i_clear, o_busy, o_clr_we, o_clr_idx).

Verification
REQ-034 Reset pulse, then idle: o_busy high for exactly 32 cycles after deassertion; all 32 indices read 0.
REQ-035 Write x5=0xDEADBEEF via port 0: same cycle raddr=5 returns 0xDEADBEEF (BYPASS=1), array holds it next cycle; BYPASS=0 returns old value that cycle.
REQ-036 Same cycle: port 0 writes x7=0x1111, port 1 writes x7=0x2222 -> x7 reads 0x2222 afterwards and bypasses 0x2222.
REQ-037 Write x0=0xFFFFFFFF on both ports -> x0 reads 0 (ZERO_REG=1); ZERO_REG=0 build reads 0xFFFFFFFF.
REQ-038 Fill x1..x31 with index value, pulse i_clear with write x3=0x55 -> write dropped, o_busy 32 cycles, all read 0, second i_clear mid-sequence not extending busy.
REQ-039 Assert i_rst at clear cycle 10 -> o_busy stays high, sequence restarts, busy deasserts 32 cycles after release.
